exu_mdu: RTL and testbench

EXU_MDU -- requirements
Module: exu_mdu

---
 rtl/exu_pkg.sv | 52 +++++
 rtl/exu_muldiv_core.sv | 113 +++++++++++
 rtl/exu_mdu.sv | 138 +++++++++++++
 tb/tb_exu_mdu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared opcode constants, FSM encoding and dispatch helpers for the
// execution-unit multiply/divide block.
package exu_pkg;

   localparam logic [5:0] ALU_ADD   = 6'd0;
   localparam logic [5:0] ALU_SUB   = 6'd1;
   localparam logic [5:0] ALU_AND   = 6'd2;
   localparam logic [5:0] ALU_OR    = 6'd3;
   localparam logic [5:0] ALU_XOR   = 6'd4;
   localparam logic [5:0] ALU_SLL   = 6'd5;
   localparam logic [5:0] ALU_SRL   = 6'd6;
   localparam logic [5:0] ALU_SRA   = 6'd7;
   localparam logic [5:0] ALU_LUI   = 6'd8;
   localparam logic [5:0] ALU_MFHI  = 6'd9;
   localparam logic [5:0] ALU_MFLO  = 6'd10;
   localparam logic [5:0] ALU_MTHI  = 6'd11;
   localparam logic [5:0] ALU_MTLO  = 6'd12;
   localparam logic [5:0] ALU_MULT  = 6'd13;
   localparam logic [5:0] ALU_MULTU = 6'd14;
   localparam logic [5:0] ALU_DIV   = 6'd15;
   localparam logic [5:0] ALU_DIVU  = 6'd16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_HOLD = 2'd3
   } mdu_state_e;

   function automatic logic op_is_mul(input logic [5:0] op);
      return (op == ALU_MULT) || (op == ALU_MULTU);
   endfunction

   function automatic logic op_is_div(input logic [5:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [5:0] op);
      return (op == ALU_MULT) || (op == ALU_DIV);
   endfunction

   // State entered when an operation is accepted.
   function automatic mdu_state_e dispatch(input logic [5:0] op);
      if (op_is_mul(op))
         return ST_MUL;
      else if (op_is_div(op))
         return ST_DIV;
      else
         return ST_HOLD;
   endfunction

endpackage

// File: rtl/exu_muldiv_core.sv
// Iterative radix-2 shift-add multiplier / restoring divider on operand
// magnitudes; one step per clock for XLEN clocks, sign fix-up on the last step.
module exu_muldiv_core
   import exu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic            is_div,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   logic              run;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_nxt;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   opb;
   logic [XLEN-1:0]   a_orig;
   logic              div_r;
   logic              neg_q;
   logic              neg_r;
   logic              dz;

   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   ma;
   logic [XLEN-1:0]   mb;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   always_comb begin
      sa = is_signed & a[XLEN-1];
      sb = is_signed & b[XLEN-1];
      ma = sa ? (~a + 1'b1) : a;
      mb = sb ? (~b + 1'b1) : b;
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      shifted = acc[2*XLEN-1:XLEN-1];
      diff    = shifted - {1'b0, opb};
      if (div_r) begin
         if (shifted >= {1'b0, opb})
            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = {sum, acc[XLEN-1:1]};
      end
   end

   // Most-negative / -1 falls out naturally: magnitude quotient 2^(XLEN-1) with no sign flip.
   always_comb begin
      prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
      quo      = acc_nxt[XLEN-1:0];
      rem      = acc_nxt[2*XLEN-1:XLEN];
      if (div_r) begin
         if (dz) begin
            lo = '1;
            hi = a_orig;
         end else begin
            lo = neg_q ? (~quo + 1'b1) : quo;
            hi = neg_r ? (~rem + 1'b1) : rem;
         end
      end else begin
         {hi, lo} = prod_fix;
      end
      done = run && (cnt == CW'(XLEN-1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
      end else if (run) begin
         if (cnt == CW'(XLEN-1))
            run <= 1'b0;
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         acc    <= {{XLEN{1'b0}}, (is_div ? ma : mb)};
         opb    <= is_div ? mb : ma;
         div_r  <= is_div;
         neg_q  <= sa ^ sb;
         neg_r  <= sa;
         dz     <= is_div && (b == '0);
         a_orig <= a;
      end else if (run) begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/exu_mdu.sv
// Execution-unit ALU / multiply-divide block: single-cycle ALU results and
// iterative MUL/DIV completions share one registered writeback with handshake.
module exu_mdu
   import exu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      rc_addr_i,
   input  logic            rc_wr_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rc_data,
   output logic [4:0]      rc_addr,
   output logic            rc_wr,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic            busy
);

   mdu_state_e state;
   mdu_state_e state_nxt;
   logic       accept;

   logic [XLEN-1:0]        alu_res;
   logic                   alu_wr;
   logic [SHW-1:0]         sh;
   logic signed [XLEN-1:0] b_s;

   logic            core_done;
   logic [XLEN-1:0] core_hi;
   logic [XLEN-1:0] core_lo;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (accept)
               state_nxt = dispatch(op_i);
         end
         ST_MUL, ST_DIV: begin
            busy = 1'b1;
            if (core_done)
               state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            accept    = in_valid && out_ready;
            if (accept)
               state_nxt = dispatch(op_i);
            else if (out_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sh      = a_i[SHW-1:0];
      b_s     = b_i;
      alu_res = '0;
      alu_wr  = 1'b1;
      case (op_i)
         ALU_ADD:  alu_res = a_i + b_i;
         ALU_SUB:  alu_res = a_i - b_i;
         ALU_AND:  alu_res = a_i & b_i;
         ALU_OR:   alu_res = a_i | b_i;
         ALU_XOR:  alu_res = a_i ^ b_i;
         ALU_SLL:  alu_res = b_i << sh;
         ALU_SRL:  alu_res = b_i >> sh;
         ALU_SRA:  alu_res = b_s >>> sh;
         ALU_LUI:  alu_res = a_i;
         ALU_MFHI: alu_res = hi_o;
         ALU_MFLO: alu_res = lo_o;
         default:  alu_wr  = 1'b0;
      endcase
   end

   exu_muldiv_core #(.XLEN(XLEN)) u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (accept && (op_is_mul(op_i) || op_is_div(op_i))),
      .is_signed (op_is_signed(op_i)),
      .is_div    (op_is_div(op_i)),
      .a         (a_i),
      .b         (b_i),
      .done      (core_done),
      .hi        (core_hi),
      .lo        (core_lo)
   );

   // MUL/DIV accept leaves rc_data=0, rc_wr=0; HI/LO land on the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rc_data <= '0;
         rc_addr <= '0;
         rc_wr   <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
      end else begin
         if (accept) begin
            rc_data <= alu_res;
            rc_addr <= rc_addr_i;
            rc_wr   <= rc_wr_i & alu_wr;
            if (op_i == ALU_MTHI)
               hi_o <= a_i;
            if (op_i == ALU_MTLO)
               lo_o <= a_i;
         end
         if (core_done) begin
            hi_o <= core_hi;
            lo_o <= core_lo;
         end
      end
   end

endmodule

// File: tb/tb_exu_mdu.sv
// Scoreboard bench for exu_mdu: XLEN=32 instance for the main function and an
// XLEN=16 instance for the narrow multiply.
module tb_exu_mdu;
   import exu_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        wr;
      logic [31:0] hi;
      logic [31:0] lo;
      bit          chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  addr_i;
   logic        wr_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rc_data;
   logic [4:0]  rc_addr;
   logic        rc_wr;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy;

   logic        v16;
   logic        rdy16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [5:0]  op16;
   logic        ov16;
   logic [15:0] d16;
   logic [4:0]  ad16;
   logic        w16;
   logic [15:0] hi16;
   logic [15:0] lo16;
   logic        busy16;

   int   checks   = 0;
   int   failures = 0;
   exp_t sbq[$];
   exp_t e_mon;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   always #5 clk = ~clk;

   exu_mdu #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_i(op), .a_i(a), .b_i(b), .rc_addr_i(addr_i), .rc_wr_i(wr_i),
      .out_valid(out_valid), .out_ready(out_ready), .rc_data(rc_data),
      .rc_addr(rc_addr), .rc_wr(rc_wr), .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
   );

   exu_mdu #(.XLEN(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
      .op_i(op16), .a_i(a16), .b_i(b16), .rc_addr_i(5'd0), .rc_wr_i(1'b0),
      .out_valid(ov16), .out_ready(1'b1), .rc_data(d16),
      .rc_addr(ad16), .rc_wr(w16), .hi_o(hi16), .lo_o(lo16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] ad, input logic w);
      exp_t   e;
      logic [4:0]  s;
      logic [63:0] p;
      longint sx;
      longint sy;
      int     ix;
      int     iy;
      s = x[4:0];
      e.data = '0; e.addr = ad; e.wr = w; e.chk_data = 1'b1;
      case (o)
         ALU_ADD:  e.data = x + y;
         ALU_SUB:  e.data = x - y;
         ALU_AND:  e.data = x & y;
         ALU_OR:   e.data = x | y;
         ALU_XOR:  e.data = x ^ y;
         ALU_SLL:  e.data = y << s;
         ALU_SRL:  e.data = y >> s;
         ALU_SRA:  e.data = (y >> s) | (y[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         ALU_LUI:  e.data = x;
         ALU_MFHI: e.data = mhi;
         ALU_MFLO: e.data = mlo;
         ALU_MTHI: begin mhi = x; e.wr = 1'b0; e.chk_data = 1'b0; end
         ALU_MTLO: begin mlo = x; e.wr = 1'b0; e.chk_data = 1'b0; end
         ALU_MULT: begin
            sx = longint'(int'(x)); sy = longint'(int'(y));
            p = 64'(sx * sy);
            {mhi, mlo} = p; e.wr = 1'b0; e.chk_data = 1'b0;
         end
         ALU_MULTU: begin
            p = {32'h0, x} * {32'h0, y};
            {mhi, mlo} = p; e.wr = 1'b0; e.chk_data = 1'b0;
         end
         ALU_DIV, ALU_DIVU: begin
            e.wr = 1'b0; e.chk_data = 1'b0;
            if (y == 32'h0) begin
               mlo = 32'hFFFF_FFFF; mhi = x;
            end else if (o == ALU_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               mlo = 32'h8000_0000; mhi = 32'h0;
            end else if (o == ALU_DIV) begin
               ix = int'(x); iy = int'(y);
               mlo = ix / iy; mhi = ix % iy;
            end else begin
               mlo = x / y; mhi = x % y;
            end
         end
         default: e.wr = 1'b0;
      endcase
      e.hi = mhi;
      e.lo = mlo;
      return e;
   endfunction

   task automatic send(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] ad, input logic w);
      exp_t e;
      @(negedge clk);
      op = o; a = x; b = y; addr_i = ad; wr_i = w; in_valid = 1'b1;
      for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
      if (!in_ready) begin
         check("send_timeout", 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      e = model(o, x, y, ad, w);
      sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && sbq.size() != 0; n++) @(negedge clk);
      check("drain", 64'(sbq.size()), 64'(0));
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'(0));
         end else begin
            e_mon = sbq.pop_front();
            if (e_mon.chk_data) check("rc_data", 64'(rc_data), 64'(e_mon.data));
            check("rc_addr", 64'(rc_addr), 64'(e_mon.addr));
            check("rc_wr", 64'(rc_wr), 64'(e_mon.wr));
            check("hi", 64'(hi_o), 64'(e_mon.hi));
            check("lo", 64'(lo_o), 64'(e_mon.lo));
         end
      end
   end

   initial begin
      int lat;
      int bc;
      logic [31:0] rx;
      logic [31:0] ry;
      logic [5:0]  ro;
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; addr_i = '0; wr_i = 1'b0;
      out_ready = 1'b1; v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

      // Reset dominates an offered MTHI
      @(negedge clk);
      op = ALU_MTHI; a = 32'hDEAD_BEEF; in_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_hi", 64'(hi_o), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_rc_data", 64'(rc_data), 64'(0));
      check("rst_rc_addr", 64'(rc_addr), 64'(0));
      check("rst_rc_wr", 64'(rc_wr), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_lo", 64'(lo_o), 64'(0));
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'(1));

      // ADD wrap with one-cycle latency
      send(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1);
      check("add_latency", 64'(out_valid), 64'(1));
      send(ALU_SUB, 32'h0, 32'h1, 5'd6, 1'b1);
      send(ALU_AND, 32'hF0F0_1234, 32'hFF00_FF00, 5'd7, 1'b0);
      send(ALU_OR,  32'h0000_00F0, 32'h0F00_000F, 5'd8, 1'b1);
      send(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd9, 1'b1);
      send(ALU_SLL, 32'h0000_0021, 32'h8000_0001, 5'd10, 1'b1);
      send(ALU_SRL, 32'h0000_001F, 32'h8000_0000, 5'd11, 1'b1);
      send(ALU_LUI, 32'h1234_0000, 32'h5, 5'd12, 1'b1);
      send(ALU_MTHI, 32'hCAFE_0001, 32'h0, 5'd13, 1'b1);
      send(ALU_MTLO, 32'hCAFE_0002, 32'h0, 5'd14, 1'b1);
      send(ALU_MFHI, 32'h0, 32'h0, 5'd15, 1'b1);
      send(ALU_MFLO, 32'h0, 32'h0, 5'd16, 1'b1);
      send(6'd63, 32'h1, 32'h2, 5'd17, 1'b1);

      // MULT -3 * 7: latency and busy duration
      send(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 5'd1, 1'b1);
      lat = 0; bc = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (out_valid) begin lat = n + 1; break; end
         if (busy) bc++;
      end
      check("mult_latency", 64'(lat), 64'(33));
      check("mult_busy_cycles", 64'(bc), 64'(32));

      send(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1);
      send(ALU_DIVU, 32'd7, 32'd0, 5'd3, 1'b1);
      send(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1);
      send(ALU_DIV,  32'd100, 32'hFFFF_FFF9, 5'd4, 1'b1);
      send(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1);
      send(ALU_MFHI, 32'h0, 32'h0, 5'd18, 1'b1);

      // Random mix
      for (int i = 0; i < 24; i++) begin
         ro = 6'($urandom_range(0, 17));
         rx = $urandom;
         ry = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         send(ro, rx, ry, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
      drain();

      // SRA held under backpressure, then consumed alongside a new accept
      @(posedge clk); #1 out_ready = 1'b0;
      send(ALU_SRA, 32'h0000_0024, 32'h8000_0000, 5'd21, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 64'(out_valid), 64'(1));
         check("hold_rc_data", 64'(rc_data), 64'(32'hF800_0000));
         check("hold_rc_addr", 64'(rc_addr), 64'(21));
         check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk); #1 out_ready = 1'b1;
      send(ALU_ADD, 32'd40, 32'd2, 5'd22, 1'b1);
      check("b2b_out_valid", 64'(out_valid), 64'(1));
      drain();

      // Reset partway through DIVU
      send(ALU_MTLO, 32'h0000_1234, 32'h0, 5'd0, 1'b0);
      send(ALU_DIVU, 32'd100, 32'd3, 5'd0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("divu_busy_before_rst", 64'(busy), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sbq.delete();
      mhi = '0; mlo = '0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_out_valid", 64'(out_valid), 64'(0));
      check("abort_hi", 64'(hi_o), 64'(0));
      check("abort_lo", 64'(lo_o), 64'(0));
      check("abort_in_ready", 64'(in_ready), 64'(1));
      send(ALU_MFLO, 32'h0, 32'h0, 5'd30, 1'b1);
      drain();

      // XLEN=16 MULTU
      @(negedge clk);
      op16 = ALU_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
      @(posedge clk); #1 v16 = 1'b0;
      lat = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (ov16) begin lat = n + 1; break; end
      end
      check("m16_latency", 64'(lat), 64'(17));
      check("m16_hi", 64'(hi16), 64'(16'hFFFE));
      check("m16_lo", 64'(lo16), 64'(16'h0001));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
